// File: rtl/mem_arbiter.sv
// Purpose: arbitrates the I-fetch and D ports onto one shared block memory interface.
// Latency: strobe one cycle after a request is sampled in IDLE; ack one cycle after mem_ready.
// Backpressure: requesters hold req until ack; a single transfer is in flight at any time.
// Build option: define MEM_ARB_RR_EN for round-robin priority; default is fixed priority, D over I.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;

  // A requester whose ack is high this cycle is still holding req for that
  // completed transfer, so it must not be seen as a fresh request.
  logic i_eff;
  logic d_eff;
  logic grant_d;

  assign i_eff = i_req & ~i_ack;
  assign d_eff = d_req & ~d_ack;

`ifdef MEM_ARB_RR_EN
  // 1 when D was the most recently granted port; resets to I.
  logic last_d;

  // On a tie, grant the port that was not served last.
  assign grant_d = d_eff & (~i_eff | ~last_d);
`else
  // Fixed priority: D always wins a tie.
  assign grant_d = d_eff;
`endif

  // Arbitration FSM with registered memory strobes, acks and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= BUSY_D;
            mem_addr <= d_addr;
            if (d_we) begin
              mem_wdata <= d_wdata;
              mem_write <= 1'b1;
            end else begin
              mem_read <= 1'b1;
            end
`ifdef MEM_ARB_RR_EN
            last_d <= 1'b1;
`endif
          end else if (i_eff) begin
            state    <= BUSY_I;
            mem_addr <= i_addr;
            mem_read <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_d <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_ack     <= 1'b1;
            i_rdata   <= mem_rdata;
            state     <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_ack     <= 1'b1;
            // Only a read transfer updates the D-side read data.
            if (mem_read) begin
              d_rdata <= mem_rdata;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
